// File: rtl/idu_dec_queue.sv
// rtl/idu_dec_queue.sv - in-order decoded-instruction queue with long-instruction ID allocation.
// Optional same-cycle empty-queue bypass: define IDU_DEC_QUEUE_BYPASS_EN.
module idu_dec_queue #(
  parameter int PAYLOAD_W    = 160,
  parameter int DEPTH        = 4,
  parameter int NUM_LONG_IDS = 4,
  localparam int ID_W        = $clog2(NUM_LONG_IDS),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [PAYLOAD_W-1:0]    in_payload_i,
  input  logic                    in_is_long_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [PAYLOAD_W-1:0]    out_payload_o,
  output logic                    out_is_long_o,
  output logic [ID_W-1:0]         out_long_id_o,
  input  logic                    commit_valid_i,
  input  logic [ID_W-1:0]         commit_id_i,
  output logic [CNT_W-1:0]        count_o,
  output logic [NUM_LONG_IDS-1:0] ids_busy_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0]    pay_mem_q [DEPTH];
  logic [DEPTH-1:0]        long_mem_q;

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NUM_LONG_IDS-1:0] ids_busy_q, ids_busy_d;

  logic                    queue_empty;
  logic                    queue_full;
  logic [PAYLOAD_W-1:0]    head_payload;
  logic                    head_is_long;
  logic [PAYLOAD_W-1:0]    sel_payload;
  logic                    sel_is_long;
  logic                    sel_present;
  logic                    bypass;
  logic                    free_any;
  logic [ID_W-1:0]         free_id;
  logic                    head_ok;
  logic                    enq;
  logic                    deq;
  logic                    pop;

  assign queue_empty = (count_q == '0);
  assign queue_full  = (count_q == CNT_W'(DEPTH));

  assign head_payload = queue_empty ? '0 : pay_mem_q[rd_ptr_q];
  assign head_is_long = ~queue_empty & long_mem_q[rd_ptr_q];

  // Lowest-index free long ID.
  always_comb begin
    free_id  = '0;
    free_any = 1'b0;
    for (int i = NUM_LONG_IDS - 1; i >= 0; i--) begin
      if (!ids_busy_q[i]) begin
        free_id  = ID_W'(i);
        free_any = 1'b1;
      end
    end
  end

`ifdef IDU_DEC_QUEUE_BYPASS_EN
  assign bypass = queue_empty & in_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    sel_payload = head_payload;
    sel_is_long = head_is_long;
    sel_present = ~queue_empty;
`ifdef IDU_DEC_QUEUE_BYPASS_EN
    if (bypass) begin
      sel_payload = in_payload_i;
      sel_is_long = in_is_long_i;
      sel_present = 1'b1;
    end
`endif
  end

  assign head_ok       = ~sel_is_long | free_any;
  assign out_valid_o   = sel_present & head_ok;
  assign out_payload_o = sel_payload;
  assign out_is_long_o = sel_is_long;
  assign out_long_id_o = (sel_is_long & free_any) ? free_id : '0;

  assign in_ready_o = ~queue_full;
  assign deq        = out_valid_o & out_ready_i;
  // A bypassed entry that dispatches immediately never occupies a slot.
  assign enq        = in_valid_i & in_ready_o & ~flush_i & ~(bypass & deq);
  assign pop        = deq & ~bypass;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ids_busy_d = ids_busy_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // Release before allocate: an allocated ID was clear this cycle, so a
    // commit naming it is a no-op and the allocation must win.
    if (commit_valid_i) begin
      ids_busy_d[commit_id_i] = 1'b0;
    end
    if (deq & sel_is_long) begin
      ids_busy_d[out_long_id_o] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ids_busy_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ids_busy_q <= ids_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      pay_mem_q[wr_ptr_q]  <= in_payload_i;
      long_mem_q[wr_ptr_q] <= in_is_long_i;
    end
  end

  assign count_o    = count_q;
  assign ids_busy_o = ids_busy_q;

endmodule

// File: doc/idu_dec_queue.md
Name: idu_dec_queue

Overview:
- Parametrised decoded-instruction queue between idu_decode and EX.
- Successor to the single-stage ID pipe register: it replaces the stall-flag register with a DEPTH-entry valid/ready FIFO.
- Adds long-instruction ID allocation and release, so dispatch of a long op blocks while every long ID is in flight.
- Payload is opaque: the packed decode fields (inst_addr, reg_we/waddr, reg1/reg2 raddr, csr_we/waddr/raddr, imm, dec_info_bus).

Parameters:
- PAYLOAD_W, 160, width of the packed decode payload.
- DEPTH, 4, queue entries; power of two, at least 2.
- NUM_LONG_IDS, 4, number of long-instruction IDs; power of two, at least 2.
- ID_W, $clog2(NUM_LONG_IDS), long ID width (derived, do not override).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid_i, input, 1, decode has an instruction.
- in_ready_o, output, 1, queue accepts an instruction.
- in_payload_i, input, PAYLOAD_W, decode payload.
- in_is_long_i, input, 1, instruction needs a long ID (mul/div/load).
- flush_i, input, 1, discard all queued entries (jump/trap).
- out_valid_o, output, 1, head is dispatchable.
- out_ready_i, input, 1, EX accepts the head.
- out_payload_o, output, PAYLOAD_W, head payload.
- out_is_long_o, output, 1, head is long.
- out_long_id_o, output, ID_W, ID assigned to the head when long.
- commit_valid_i, input, 1, long instruction completed.
- commit_id_i, input, ID_W, ID of the completed long instruction.
- count_o, output, CNT_W, current occupancy.
- ids_busy_o, output, NUM_LONG_IDS, busy bitmap of long IDs.

Behaviour:
- Reset and clock: single clock clk. Reset rst is synchronous and active-high. In the cycle after rst is sampled high:
  - count_o=0, ids_busy_o=0, out_valid_o=0, out_payload_o=0, out_is_long_o=0, out_long_id_o=0, in_ready_o=1.
  - Read/write pointers are 0.
  - rst overrides flush_i, commit and any fire in the same cycle.
- Enqueue: enq = in_valid_i & in_ready_o & ~flush_i.
  - in_ready_o = (count_o != DEPTH). No same-cycle full pass-through: a full queue deasserts ready even when a dequeue occurs that cycle.
- Head availability:
  - head_ok = ~head_is_long | free_any, where free_any = |~ids_busy.
  - out_valid_o = (count_o != 0) & head_ok.
  - Dequeue: deq = out_valid_o & out_ready_i.
- Ordering: in-order only. A blocked long head also blocks the younger entries behind it.
- Latency: an entry written at edge N is visible on out_* after edge N, i.e. one cycle of minimum enqueue-to-dispatch.
- Payload outputs: out_payload_o and out_is_long_o come from the head slot and are forced to 0 when count_o==0.
- Pointers: ID_W-style wrap at DEPTH with natural power-of-two rollover. count_o changes by +1 on enq only, -1 on deq only, and is unchanged on both.
- Long ID allocation:
  - out_long_id_o = lowest-index clear bit of ids_busy (priority encoder), combinational. It is 0 when none is free or the head is not long.
  - On deq of a long head, the bit for out_long_id_o is set at the next edge.
- Release: commit_valid_i clears bit commit_id_i at the next edge.
  - A freed ID is not allocatable until the following cycle (no same-cycle bypass).
  - Commit of an already-clear ID is ignored.
- Simultaneous allocate and commit on different IDs: both take effect.
- Flush: at the next edge, count_o=0 and the pointers are reset.
  - A deq that fires in the flush cycle still counts as dispatched, including its ID allocation.
  - ids_busy is NOT cleared by flush: long ops already in flight still commit.
- count_o and ids_busy_o are registered outputs.

Optional Feature:
- Macro IDU_DEC_QUEUE_BYPASS_EN.
- Defined: when count_o==0 & in_valid_i & ~flush_i, the input drives out_* combinationally in the same cycle. Long gating still applies (out_valid_o requires free_any if in_is_long_i). If out_ready_i fires, the entry is not written, giving zero-cycle latency; otherwise it is enqueued normally.
- Undefined: minimum latency is one cycle, and out_* depend only on registered state.

Test Plan:
- Reset then write 4 payloads 0x1..0x4 with out_ready_i=0: count_o reaches 4 and in_ready_o=0 on the 4th cycle after the first write. Drain: payloads appear in order 0x1..0x4, then count_o=0 and out_valid_o=0.
- Long allocation: enqueue 5 long ops with out_ready_i=1.
  - IDs 0,1,2,3 are dispatched.
  - The 5th is held with out_valid_o=0 and ids_busy_o=4'b1111.
  - commit_id_i=2: the 5th dispatches one cycle after the commit edge with out_long_id_o=2.
- Blocked head: head long with all IDs busy, a non-long op behind it. Neither dispatches until a commit; order is preserved.
- Flush with 3 entries queued, 2 IDs busy, and in_valid_i=1: next cycle count_o=0, out_valid_o=0, ids_busy_o unchanged, input not captured.
- Simultaneous enq/deq at count_o=2 for 10 cycles: count_o stays 2 and the payload sequence is intact. Pointer wrap is exercised past DEPTH.
- Commit of a clear ID (id 3 while busy=4'b0001) combined with allocation of id 1 in the same cycle: busy becomes 4'b0011.
